// File: rtl/dionysus_clk_pkg.sv
// Shared definitions for the Dionysus clock supervisor: FSM state encoding and
// an elaboration-time clog2 helper.
package dionysus_clk_pkg;

  localparam logic [2:0] ST_PLL_RST   = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_RELEASE   = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;
  localparam logic [2:0] ST_FAULT     = 3'd5;

  typedef enum logic [2:0] {
    PLL_RST   = ST_PLL_RST,
    WAIT_LOCK = ST_WAIT_LOCK,
    STABLE    = ST_STABLE,
    RELEASE   = ST_RELEASE,
    RUN       = ST_RUN,
    FAULT     = ST_FAULT
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dionysus_sync_2ff.sv
// Two-flop synchroniser for asynchronous status pins; synchronous active-low reset
// clears both stages to 0.
module dionysus_sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_d, meta_q;
  logic [W-1:0] sync_d, sync_q;

  // Next-state for the two synchroniser stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/dionysus_clk_supervisor.sv
// PLL reset/lock supervisor: qualifies lock, releases per-domain resets in a
// staggered order, and re-runs the sequence on lock loss with bounded retries.
module dionysus_clk_supervisor
  import dionysus_clk_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int PLL_RST_CYCLES  = 16,
  parameter int LOCK_TIMEOUT    = 1000,
  parameter int STABLE_CYCLES   = 64,
  parameter int RELEASE_STAGGER = 8,
  parameter int MAX_RETRIES     = 3,
  parameter int CNT_W           = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 pll_locked,
  input  logic [NUM_CH-1:0]                    ch_en,
  input  logic                                 force_relock,
  output logic                                 pll_rst,
  output logic [NUM_CH-1:0]                    ch_rst,
  output logic                                 ready,
  output logic                                 fault,
  output logic [clog2(MAX_RETRIES+1)-1:0]      retry_count,
  output logic [CNT_W-1:0]                     lock_loss_count
);

  localparam int RC_W = clog2(MAX_RETRIES + 1);

  logic              lock_s;
  state_e            state_d, state_q;
  logic [CNT_W-1:0]  timer_d, timer_q;
  logic [NUM_CH-1:0] pending_d, pending_q;
  logic              pll_rst_d, pll_rst_q;
  logic [NUM_CH-1:0] ch_rst_d, ch_rst_q;
  logic              ready_d, ready_q;
  logic              fault_d, fault_q;
  logic [RC_W-1:0]   retry_d, retry_q;
  logic [CNT_W-1:0]  loss_d, loss_q;
  logic              fail_s;
  logic [RC_W-1:0]   retry_inc_s;
  logic [NUM_CH-1:0] low_s;
  logic [NUM_CH-1:0] entry_low_s;

  dionysus_sync_2ff #(.W(1)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  // Sequencer next-state; pending holds enabled channels not yet released.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    pending_d   = pending_q;
    pll_rst_d   = pll_rst_q;
    ch_rst_d    = ch_rst_q;
    ready_d     = ready_q;
    fault_d     = fault_q;
    retry_d     = retry_q;
    loss_d      = loss_q;
    fail_s      = 1'b0;
    retry_inc_s = retry_q + RC_W'(1);
    low_s       = pending_q & (~pending_q + NUM_CH'(1));
    entry_low_s = ch_en & (~ch_en + NUM_CH'(1));

    case (state_q)
      PLL_RST: begin
        pll_rst_d = 1'b1;
        ch_rst_d  = '1;
        if (timer_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
          state_d   = WAIT_LOCK;
          pll_rst_d = 1'b0;
          timer_d   = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          timer_d = '0;
        end else if (timer_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          fail_s = 1'b1;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      STABLE: begin
        if (!lock_s) begin
          fail_s = 1'b1;
        end else if (timer_q == CNT_W'(STABLE_CYCLES - 1)) begin
          // First enabled channel drops in the same edge that enters RELEASE.
          state_d   = RELEASE;
          timer_d   = '0;
          ch_rst_d  = ~entry_low_s;
          pending_d = ch_en & ~entry_low_s;
          ready_d   = (ch_en == '0);
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          fail_s = 1'b1;
        end else if (pending_q == '0) begin
          state_d = RUN;
          ready_d = 1'b1;
          retry_d = '0;
        end else if (timer_q == CNT_W'(RELEASE_STAGGER - 1)) begin
          ch_rst_d  = ch_rst_q & ~low_s;
          pending_d = pending_q & ~low_s;
          timer_d   = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d   = PLL_RST;
          pll_rst_d = 1'b1;
          timer_d   = '0;
          ch_rst_d  = '1;
          ready_d   = 1'b0;
          loss_d    = (loss_q == {CNT_W{1'b1}}) ? loss_q : loss_q + CNT_W'(1);
        end else begin
          // A dropped enable sticks at 1 until the next full sequence.
          ch_rst_d = ch_rst_q | ~ch_en;
        end
      end
      FAULT: begin
        fault_d   = 1'b1;
        pll_rst_d = 1'b0;
        ch_rst_d  = '1;
        ready_d   = 1'b0;
      end
      default: begin
        state_d   = PLL_RST;
        pll_rst_d = 1'b1;
        timer_d   = '0;
        ch_rst_d  = '1;
        ready_d   = 1'b0;
      end
    endcase

    if (force_relock) begin
      state_d   = PLL_RST;
      pll_rst_d = 1'b1;
      timer_d   = '0;
      pending_d = '0;
      ch_rst_d  = '1;
      ready_d   = 1'b0;
      fault_d   = 1'b0;
      retry_d   = '0;
      loss_d    = loss_q;
    end else if (fail_s) begin
      retry_d   = retry_inc_s;
      timer_d   = '0;
      pending_d = '0;
      ch_rst_d  = '1;
      ready_d   = 1'b0;
      if (retry_inc_s == RC_W'(MAX_RETRIES)) begin
        state_d   = FAULT;
        fault_d   = 1'b1;
        pll_rst_d = 1'b0;
      end else begin
        state_d   = PLL_RST;
        pll_rst_d = 1'b1;
      end
    end else begin
      fail_s = 1'b0;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= PLL_RST;
      timer_q   <= '0;
      pending_q <= '0;
      pll_rst_q <= 1'b1;
      ch_rst_q  <= '1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
      retry_q   <= '0;
      loss_q    <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      pll_rst_q <= pll_rst_d;
      ch_rst_q  <= ch_rst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
    end
  end

  assign pll_rst         = pll_rst_q;
  assign ch_rst          = ch_rst_q;
  assign ready           = ready_q;
  assign fault           = fault_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_dionysus_clk_supervisor.sv
// Directed bench for dionysus_clk_supervisor: a phase/elapsed-time model checked
// every cycle, plus literal expectations at hand-computed cycles.
module tb_dionysus_clk_supervisor;

  localparam int NCH = 3;
  localparam int PRC = 4;
  localparam int LTO = 20;
  localparam int SC  = 8;
  localparam int STG = 3;
  localparam int MR  = 2;

  localparam int P_RST  = 0;
  localparam int P_WAIT = 1;
  localparam int P_STAB = 2;
  localparam int P_REL  = 3;
  localparam int P_RUN  = 4;
  localparam int P_FLT  = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           pll_locked = 1'b0;
  logic [NCH-1:0] ch_en = 3'b111;
  logic           force_relock = 1'b0;
  logic           pll_rst;
  logic [NCH-1:0] ch_rst;
  logic           ready;
  logic           fault;
  logic [1:0]     retry_count;
  logic [15:0]    lock_loss_count;

  int errors = 0;
  int checks = 0;

  dionysus_clk_supervisor #(
    .NUM_CH(NCH), .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(LTO), .STABLE_CYCLES(SC),
    .RELEASE_STAGGER(STG), .MAX_RETRIES(MR), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .ch_en(ch_en),
    .force_relock(force_relock), .pll_rst(pll_rst), .ch_rst(ch_rst), .ready(ready),
    .fault(fault), .retry_count(retry_count), .lock_loss_count(lock_loss_count)
  );

  always #5 clk = ~clk;

  // Model state: current phase, edge index at which it was entered, counters.
  int             cyc = 0;
  int             rel = 0;
  int             ph = P_RST;
  int             t0 = 0;
  int             rc = 0;
  int             loss = 0;
  logic           s1 = 1'b0, s2 = 1'b0;
  logic [NCH-1:0] en_snap = '0;
  logic [NCH-1:0] live = '0;
  logic           valid = 1'b0;
  logic           exp_pll;
  logic [NCH-1:0] exp_ch;
  logic           exp_ready, exp_fault;
  logic [1:0]     exp_rc;
  logic [15:0]    exp_loss;

  function automatic int popc(input logic [NCH-1:0] v);
    int n = 0;
    for (int i = 0; i < NCH; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int rel_end(input logic [NCH-1:0] v);
    return (popc(v) == 0) ? 1 : (popc(v) - 1) * STG + 1;
  endfunction

  always @(posedge clk) begin : model
    logic lk;
    logic fail;
    int   el;
    int   rank;
    cyc = cyc + 1;
    lk = s2;
    fail = 1'b0;
    if (!rst) begin
      s1 = 1'b0; s2 = 1'b0;
      ph = P_RST; t0 = cyc; rc = 0; loss = 0; rel = 0; valid = 1'b1;
    end else begin
      s2 = s1; s1 = pll_locked;
      rel = rel + 1;
      el = cyc - t0;
      if (force_relock) begin
        ph = P_RST; t0 = cyc; rc = 0;
      end else begin
        case (ph)
          P_RST:  if (el == PRC) begin ph = P_WAIT; t0 = cyc; end
          P_WAIT: if (lk) begin ph = P_STAB; t0 = cyc; end
                  else if (el == LTO) fail = 1'b1;
          P_STAB: if (!lk) fail = 1'b1;
                  else if (el == SC) begin ph = P_REL; t0 = cyc; en_snap = ch_en; end
          P_REL:  if (!lk) fail = 1'b1;
                  else if (el == rel_end(en_snap)) begin ph = P_RUN; live = en_snap; rc = 0; end
          P_RUN:  if (!lk) begin
                    if (loss < 65535) loss = loss + 1;
                    ph = P_RST; t0 = cyc;
                  end else live = live & ch_en;
          default: ;
        endcase
      end
      if (fail) begin
        rc = rc + 1; t0 = cyc;
        ph = (rc == MR) ? P_FLT : P_RST;
      end
    end
    el = cyc - t0;
    exp_pll = (ph == P_RST);
    exp_fault = (ph == P_FLT);
    exp_ready = (ph == P_RUN) || (ph == P_REL && popc(en_snap) == 0);
    exp_ch = '1;
    if (ph == P_REL) begin
      rank = 0;
      for (int i = 0; i < NCH; i++) begin
        if (en_snap[i]) begin
          if (el >= rank * STG) exp_ch[i] = 1'b0;
          rank = rank + 1;
        end
      end
    end else if (ph == P_RUN) begin
      exp_ch = ~live;
    end
    exp_rc = 2'(rc);
    exp_loss = 16'(loss);
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (valid) begin
      checks = checks + 1;
      if ({pll_rst, ch_rst, ready, fault, retry_count, lock_loss_count} !==
          {exp_pll, exp_ch, exp_ready, exp_fault, exp_rc, exp_loss}) begin
        errors = errors + 1;
        $display("FAIL model rel=%0d got pll_rst=%b ch_rst=%b ready=%b fault=%b retry=%0d loss=%0d want pll_rst=%b ch_rst=%b ready=%b fault=%b retry=%0d loss=%0d",
                 rel, pll_rst, ch_rst, ready, fault, retry_count, lock_loss_count,
                 exp_pll, exp_ch, exp_ready, exp_fault, exp_rc, exp_loss);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks = checks + 1;
    if (act !== want) begin
      errors = errors + 1;
      $display("FAIL %s rel=%0d got=%0h want=%0h", nm, rel, act, want);
    end
  endtask

  task automatic wait_rel(input int k);
    int n = 0;
    while (rel != k && n < 300) begin
      @(negedge clk);
      n = n + 1;
    end
    if (rel != k) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL wait_rel got=%0d want=%0d", rel, k);
    end
  endtask

  task automatic do_reset(input logic [NCH-1:0] en);
    rst = 1'b0; force_relock = 1'b0; pll_locked = 1'b0; ch_en = en;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // Bring-up, lock loss in RUN, force coincident with lock loss, rst in RELEASE.
    do_reset(3'b111);
    chk("rst_pll_rst", 32'(pll_rst), 32'd1);
    chk("rst_ch_rst", 32'(ch_rst), 32'h7);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_retry", 32'(retry_count), 32'd0);
    chk("rst_loss", 32'(lock_loss_count), 32'd0);
    wait_rel(3);  chk("a_pll_hi3", 32'(pll_rst), 32'd1);
    wait_rel(4);  chk("a_pll_lo4", 32'(pll_rst), 32'd0);
    wait_rel(6);  pll_locked = 1'b1;
    wait_rel(16); chk("a_ch16", 32'(ch_rst), 32'h7);
    wait_rel(17); chk("a_ch17", 32'(ch_rst), 32'h6);
    wait_rel(20); chk("a_ch20", 32'(ch_rst), 32'h4);
    wait_rel(23); chk("a_ch23", 32'(ch_rst), 32'h0); chk("a_rdy23", 32'(ready), 32'd0);
    wait_rel(24); chk("a_rdy24", 32'(ready), 32'd1); chk("a_flt24", 32'(fault), 32'd0);
    wait_rel(30); pll_locked = 1'b0;
    wait_rel(31); pll_locked = 1'b1;
    wait_rel(32); chk("a_rdy32", 32'(ready), 32'd1);
    wait_rel(33); chk("a_ch33", 32'(ch_rst), 32'h7); chk("a_rdy33", 32'(ready), 32'd0);
    chk("a_loss33", 32'(lock_loss_count), 32'd1); chk("a_pll33", 32'(pll_rst), 32'd1);
    wait_rel(36); chk("a_pll36", 32'(pll_rst), 32'd1);
    wait_rel(37); chk("a_pll37", 32'(pll_rst), 32'd0);
    wait_rel(45); chk("a_ch45", 32'(ch_rst), 32'h7);
    wait_rel(46); chk("a_ch46", 32'(ch_rst), 32'h6);
    wait_rel(53); chk("a_rdy53", 32'(ready), 32'd1);
    wait_rel(60); pll_locked = 1'b0;
    wait_rel(61); pll_locked = 1'b1;
    wait_rel(62); force_relock = 1'b1;
    wait_rel(63); force_relock = 1'b0;
    chk("a_loss63", 32'(lock_loss_count), 32'd1); chk("a_rdy63", 32'(ready), 32'd0);
    chk("a_pll63", 32'(pll_rst), 32'd1); chk("a_retry63", 32'(retry_count), 32'd0);
    wait_rel(76); chk("a_ch76", 32'(ch_rst), 32'h6);
    wait_rel(77); chk("a_ch77", 32'(ch_rst), 32'h6);
    rst = 1'b0;
    @(negedge clk);
    chk("a_rstrel_pll", 32'(pll_rst), 32'd1); chk("a_rstrel_ch", 32'(ch_rst), 32'h7);
    chk("a_rstrel_rdy", 32'(ready), 32'd0); chk("a_rstrel_loss", 32'(lock_loss_count), 32'd0);

    // Sparse enable mask, then an enable drop/re-enable while running.
    do_reset(3'b101);
    wait_rel(6);  pll_locked = 1'b1;
    wait_rel(17); chk("b_ch17", 32'(ch_rst), 32'h6);
    wait_rel(19); chk("b_ch19", 32'(ch_rst), 32'h6);
    wait_rel(20); chk("b_ch20", 32'(ch_rst), 32'h2); chk("b_rdy20", 32'(ready), 32'd0);
    wait_rel(21); chk("b_rdy21", 32'(ready), 32'd1);
    wait_rel(25); ch_en = 3'b100;
    wait_rel(26); chk("b_ch26", 32'(ch_rst), 32'h3);
    wait_rel(27); ch_en = 3'b101;
    wait_rel(28); chk("b_ch28", 32'(ch_rst), 32'h3);

    // Lock glitch during STABLE.
    do_reset(3'b111);
    wait_rel(6);  pll_locked = 1'b1;
    wait_rel(12); pll_locked = 1'b0;
    wait_rel(13); pll_locked = 1'b1;
    wait_rel(14); chk("c_retry14", 32'(retry_count), 32'd0); chk("c_pll14", 32'(pll_rst), 32'd0);
    wait_rel(15); chk("c_retry15", 32'(retry_count), 32'd1); chk("c_pll15", 32'(pll_rst), 32'd1);
    chk("c_ch15", 32'(ch_rst), 32'h7);
    wait_rel(27); chk("c_ch27", 32'(ch_rst), 32'h7);
    wait_rel(28); chk("c_ch28", 32'(ch_rst), 32'h6);
    wait_rel(35); chk("c_rdy35", 32'(ready), 32'd1); chk("c_retry35", 32'(retry_count), 32'd0);

    // Lock never arrives: two timeouts into FAULT, then force_relock.
    do_reset(3'b111);
    wait_rel(3);  chk("d_pll3", 32'(pll_rst), 32'd1);
    wait_rel(4);  chk("d_pll4", 32'(pll_rst), 32'd0);
    wait_rel(23); chk("d_pll23", 32'(pll_rst), 32'd0); chk("d_retry23", 32'(retry_count), 32'd0);
    wait_rel(24); chk("d_pll24", 32'(pll_rst), 32'd1); chk("d_retry24", 32'(retry_count), 32'd1);
    wait_rel(27); chk("d_pll27", 32'(pll_rst), 32'd1);
    wait_rel(28); chk("d_pll28", 32'(pll_rst), 32'd0);
    wait_rel(47); chk("d_flt47", 32'(fault), 32'd0);
    wait_rel(48); chk("d_flt48", 32'(fault), 32'd1); chk("d_retry48", 32'(retry_count), 32'd2);
    chk("d_pll48", 32'(pll_rst), 32'd0); chk("d_ch48", 32'(ch_rst), 32'h7);
    wait_rel(55); chk("d_flt55", 32'(fault), 32'd1); force_relock = 1'b1;
    wait_rel(56); force_relock = 1'b0;
    chk("d_flt56", 32'(fault), 32'd0); chk("d_pll56", 32'(pll_rst), 32'd1);
    chk("d_retry56", 32'(retry_count), 32'd0);
    wait_rel(59); chk("d_pll59", 32'(pll_rst), 32'd1);
    wait_rel(60); chk("d_pll60", 32'(pll_rst), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog rel=%0d", rel);
    $fatal(1, "watchdog expired");
  end

endmodule
